alu_core: RTL and testbench

ALU_CORE -- requirements
Module: alu_core

---
 rtl/alu_core_if.sv | 31 +++
 rtl/alu_core.sv | 137 +++++++++++++
 tb/tb_alu_core.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_core_if.sv
// alu_core_if: operand, control and registered result/flag bundle for alu_core.
// Latency: none; this is a wiring bundle only.
// Backpressure: none; the master drives a new operation every cycle.
interface alu_core_if #(
    parameter int WIDTH = 32
);
    // operands and operation controls, driven by the requester
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       alu_sel;
    logic             add_sel;
    logic             arith_sel;
    logic [2:0]       comp_sel;
    logic             sign;

    // registered result and flags, driven by the ALU
    logic [WIDTH-1:0] z;
    logic             overflow;
    logic             zero;
    logic             cflag;

    modport master (
        output a, b, alu_sel, add_sel, arith_sel, comp_sel, sign,
        input  z, overflow, zero, cflag
    );

    modport slave (
        input  a, b, alu_sel, add_sel, arith_sel, comp_sel, sign,
        output z, overflow, zero, cflag
    );
endinterface

// File: rtl/alu_core.sv
// alu_core: ALU with add/sub, OR/AND/XOR, shifts, compare and pass-B, plus overflow/zero/carry flags.
// Latency: 1 cycle; result and flags are registered on every rising clk.
// Backpressure: none; a new operation is accepted every cycle.
// Optional feature: define ALU_CORE_SRA_EN to build the arithmetic right shift (arith_sel).
module alu_core #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    alu_core_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_SLL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_CMP  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam logic [1:0] CMP_GT = 2'b00;
    localparam logic [1:0] CMP_GE = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b10;
    localparam logic [1:0] CMP_LE = 2'b11;

    // shared adder: add for OP_ADD, always subtract for compare
    logic             sub_en;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             add_ovf;

    // shifter
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sll_res;
    logic [WIDTH-1:0] srl_res;
    logic [WIDTH-1:0] shr_res;

    // comparator
    logic             eq;
    logic             lt_u;
    logic             lt_s;
    logic             lt;
    logic             cmp_res;

    // next-state values
    logic [WIDTH-1:0] z_next;
    logic             ovf_next;
    logic             c_next;

    assign sub_en   = (bus.alu_sel == OP_CMP) ? 1'b1 : bus.add_sel;
    assign add_b    = sub_en ? ~bus.b : bus.b;
    assign sum_full = {1'b0, bus.a} + {1'b0, add_b} + {{WIDTH{1'b0}}, sub_en};
    assign sum      = sum_full[WIDTH-1:0];
    assign carry    = sum_full[WIDTH];
    // signed overflow: both adder operands share a sign that the sum does not
    assign add_ovf  = (bus.a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);

    // only the low bits of b count as a shift amount
    assign shamt    = bus.b[SHW-1:0];
    assign sll_res  = bus.a << shamt;
    assign srl_res  = bus.a >> shamt;

`ifdef ALU_CORE_SRA_EN
    // kept in its own signed assignment so >>> is not forced to a logical shift
    logic signed [WIDTH-1:0] sra_res;
    assign sra_res = $signed(bus.a) >>> shamt;
    assign shr_res = bus.arith_sel ? $unsigned(sra_res) : srl_res;
`else
    // no sign-fill path; arith_sel has no effect in this build
    logic unused_arith_sel;
    assign unused_arith_sel = bus.arith_sel;
    assign shr_res          = srl_res;
`endif

    // less-than from the a-b subtraction: borrow for unsigned, sum sign corrected by overflow for signed
    assign eq   = (bus.a == bus.b);
    assign lt_u = ~carry;
    assign lt_s = sum[WIDTH-1] ^ add_ovf;
    assign lt   = bus.sign ? lt_s : lt_u;

    // pick the compare predicate; EQ/NE ignore sign
    always_comb begin
        cmp_res = 1'b0;
        if (bus.comp_sel[2]) begin
            cmp_res = bus.comp_sel[0] ? ~eq : eq;
        end else begin
            case (bus.comp_sel[1:0])
                CMP_GT:  cmp_res = ~lt & ~eq;
                CMP_GE:  cmp_res = ~lt;
                CMP_LT:  cmp_res = lt;
                CMP_LE:  cmp_res = lt | eq;
                default: cmp_res = 1'b0;
            endcase
        end
    end

    // result mux; flags are only meaningful for add/sub
    always_comb begin
        z_next   = '0;
        ovf_next = 1'b0;
        c_next   = 1'b0;
        case (bus.alu_sel)
            OP_ADD: begin
                z_next   = sum;
                ovf_next = add_ovf;
                c_next   = carry;
            end
            OP_OR:   z_next = bus.a | bus.b;
            OP_AND:  z_next = bus.a & bus.b;
            OP_XOR:  z_next = bus.a ^ bus.b;
            OP_SLL:  z_next = sll_res;
            OP_SHR:  z_next = shr_res;
            OP_CMP:  z_next = {{(WIDTH-1){1'b0}}, cmp_res};
            OP_PASS: z_next = bus.b;
            default: z_next = '0;
        endcase
    end

    // output registers; reset clears everything immediately and drops any in-flight result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.z        <= '0;
            bus.overflow <= 1'b0;
            bus.zero     <= 1'b0;
            bus.cflag    <= 1'b0;
        end else begin
            bus.z        <= z_next;
            bus.overflow <= ovf_next;
            bus.zero     <= (z_next == '0);
            bus.cflag    <= c_next;
        end
    end
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed vector table plus reset/latency sequences for alu_core.
// Latency: checks results one clk after inputs are applied.
// Backpressure: none; one vector per cycle.
module tb_alu_core;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    alu_core_if #(.WIDTH(32)) bus ();

    alu_core #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  alu_sel;
        logic        add_sel;
        logic        arith_sel;
        logic [2:0]  comp_sel;
        logic        sign;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ez;
        logic        eovf;
        logic        ezero;
        logic        ec;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] op, input logic as, input logic ar,
                                input logic [2:0] cs, input logic sg,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] ez, input logic eo, input logic ezr,
                                input logic ec);
        vec_t v;
        v.alu_sel = op; v.add_sel = as; v.arith_sel = ar; v.comp_sel = cs; v.sign = sg;
        v.a = a; v.b = b; v.ez = ez; v.eovf = eo; v.ezero = ezr; v.ec = ec;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input logic [31:0] ez, input logic eo,
                             input logic ezr, input logic ec);
        check({nm, " z"},        bus.z,                 ez);
        check({nm, " overflow"}, {31'b0, bus.overflow}, {31'b0, eo});
        check({nm, " zero"},     {31'b0, bus.zero},     {31'b0, ezr});
        check({nm, " cflag"},    {31'b0, bus.cflag},    {31'b0, ec});
    endtask

    task automatic drive(input vec_t v);
        bus.alu_sel   = v.alu_sel;
        bus.add_sel   = v.add_sel;
        bus.arith_sel = v.arith_sel;
        bus.comp_sel  = v.comp_sel;
        bus.sign      = v.sign;
        bus.a         = v.a;
        bus.b         = v.b;
    endtask

    initial begin
        logic [31:0] sra_exp;
        total = 0;
        bad   = 0;
`ifdef ALU_CORE_SRA_EN
        sra_exp = 32'hFFFFC000;
`else
        sra_exp = 32'h00004000;
`endif
        //                op      as    ar    cs      sg    a             b             z             ovf   zero  c
        vecs.push_back(mk(3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 32'h00000014, 32'h00000035, 32'h00000049, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(3'b000, 1'b1, 1'b1, 3'b101, 1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(3'b001, 1'b1, 1'b1, 3'b111, 1'b1, 32'h11111111, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'b010, 1'b0, 1'b0, 3'b000, 1'b0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(3'b011, 1'b1, 1'b0, 3'b010, 1'b1, 32'h12345678, 32'hFFFF0000, 32'hEDCB5678, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'b100, 1'b1, 1'b1, 3'b000, 1'b1, 32'h00000001, 32'hFFFFFFE4, 32'h00000010, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'b100, 1'b0, 1'b0, 3'b000, 1'b0, 32'h80000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'b101, 1'b0, 1'b0, 3'b000, 1'b0, 32'h80000000, 32'h00000011, 32'h00004000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'b101, 1'b0, 1'b1, 3'b000, 1'b0, 32'h80000000, 32'h00000011, sra_exp,      1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'b101, 1'b0, 1'b1, 3'b000, 1'b0, 32'h80000000, 32'h00000020, 32'h80000000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'b101, 1'b1, 1'b1, 3'b000, 1'b1, 32'h7FFFFFFF, 32'h00000004, 32'h07FFFFFF, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'b110, 1'b0, 1'b0, 3'b010, 1'b0, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'b110, 1'b0, 1'b1, 3'b010, 1'b1, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(3'b110, 1'b0, 1'b0, 3'b010, 1'b1, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'b110, 1'b0, 1'b0, 3'b110, 1'b1, 32'h0000FFFF, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'b110, 1'b1, 1'b0, 3'b101, 1'b0, 32'h0000FFFF, 32'h0000FFFF, 32'h00000000, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(3'b110, 1'b0, 1'b0, 3'b100, 1'b0, 32'h00000005, 32'h00000006, 32'h00000000, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(3'b110, 1'b0, 1'b0, 3'b000, 1'b1, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'b110, 1'b0, 1'b0, 3'b000, 1'b0, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(3'b110, 1'b0, 1'b0, 3'b000, 1'b0, 32'h00000007, 32'h00000007, 32'h00000000, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(3'b110, 1'b0, 1'b0, 3'b001, 1'b0, 32'h00000007, 32'h00000007, 32'h00000001, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'b110, 1'b0, 1'b0, 3'b011, 1'b0, 32'h00000008, 32'h00000007, 32'h00000000, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(3'b110, 1'b0, 1'b0, 3'b011, 1'b1, 32'hFFFFFFF8, 32'h00000007, 32'h00000001, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'b111, 1'b1, 1'b1, 3'b011, 1'b1, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0));

        // reset asserted before any clock: outputs cleared asynchronously
        rst = 1'b0;
        drive(vecs[0]);
        #1 rst = 1'b1;
        #1 check_all("reset_async", 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 check_all("reset_held", 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // table-driven vectors, one per cycle
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1 check_all($sformatf("vec%0d", i), vecs[i].ez, vecs[i].eovf, vecs[i].ezero, vecs[i].ec);
        end

        // latency: output must hold until the next rising edge
        @(negedge clk);
        drive(mk(3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0, 32'hAAAAAAAA, 32'h0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1 check_all("pass_a", 32'hAAAAAAAA, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(mk(3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 32'h2, 32'h3, 32'h0, 1'b0, 1'b0, 1'b0));
        #1 check_all("hold_before_edge", 32'hAAAAAAAA, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 check_all("add_after_edge", 32'h00000005, 1'b0, 1'b0, 1'b0);

        // result then mid-stream reset between clocks discards in-flight op
        @(negedge clk);
        drive(mk(3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1 check_all("pre_reset", 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drive(mk(3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 32'h00000014, 32'h00000035, 32'h0, 1'b0, 1'b0, 1'b0));
        #2 rst = 1'b1;
        #1 check_all("midreset_async", 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 check_all("midreset_held", 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check_all("post_reset_first", 32'h00000049, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
